// File: rtl/time_display_scan.sv
// 12-hour time display stage: snapshots the packed time word, converts two fields to BCD
// with a sequential double-dabble engine, and scans a 4-digit active-low 7-segment display.
module time_display_scan #(
  parameter int unsigned DIGIT_HOLD = 1,
  parameter bit          HR_ZERO_12 = 1'b1
) (
  input  logic        kh_clk,
  input  logic        reset,
  input  logic [26:0] disp_time,
  input  logic        show_ms,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        range_err
);

  typedef enum logic [1:0] {LOAD, CONV_A, CONV_B, COMMIT} state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  state_e          state_q;
  logic [3:0]      iter_q;
  logic            mode_q, sec0_q, err_snap_q;
  logic [9:0]      fb_q, bin_q;
  logic [11:0]     bcd_q;
  logic [7:0]      a_bcd_q;
  logic [3:0][6:0] dig_q;
  logic            dp_lit_q, range_err_q;

  logic [1:0]      idx_q;
  logic [15:0]     hold_q;
  logic [3:0]      an_q;
  logic [6:0]      seg_q;
  logic            dp_q;

  logic [4:0]  hr_w;
  logic [5:0]  min_w, sec_w;
  logic [9:0]  ms_w, field_a_w, field_b_w;
  logic        err_w;
  logic [11:0] bcd_adj, bcd_d;
  logic [9:0]  bin_d;

  always_comb begin
    hr_w      = disp_time[26:22];
    min_w     = disp_time[21:16];
    sec_w     = disp_time[15:10];
    ms_w      = disp_time[9:0];
    err_w     = (hr_w > 5'd12) || (min_w > 6'd59) || (sec_w > 6'd59) || (ms_w > 10'd999);
    field_a_w = show_ms ? {4'd0, sec_w}
              : ((HR_ZERO_12 && hr_w == 5'd0) ? 10'd12 : {5'd0, hr_w});
    field_b_w = show_ms ? ms_w : {4'd0, min_w};
  end

  // One double-dabble iteration: correct nibbles >= 5, then shift BCD:binary left by one.
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    {bcd_d, bin_d} = {bcd_adj[10:0], bin_q, 1'b0};
  end

  always_ff @(posedge kh_clk or negedge reset) begin
    if (!reset) begin
      state_q     <= LOAD;
      iter_q      <= '0;
      mode_q      <= 1'b0;
      sec0_q      <= 1'b0;
      err_snap_q  <= 1'b0;
      fb_q        <= '0;
      bin_q       <= '0;
      bcd_q       <= '0;
      a_bcd_q     <= '0;
      dig_q       <= '1;
      dp_lit_q    <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          mode_q     <= show_ms;
          sec0_q     <= sec_w[0];
          err_snap_q <= err_w;
          fb_q       <= field_b_w;
          bin_q      <= field_a_w;
          bcd_q      <= '0;
          iter_q     <= '0;
          state_q    <= CONV_A;
        end
        CONV_A: begin
          if (iter_q == 4'd9) begin
            a_bcd_q <= bcd_d[7:0];
            bin_q   <= fb_q;
            bcd_q   <= '0;
            iter_q  <= '0;
            state_q <= CONV_B;
          end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            iter_q <= iter_q + 4'd1;
          end
        end
        CONV_B: begin
          bin_q <= bin_d;
          bcd_q <= bcd_d;
          if (iter_q == 4'd9) begin
            iter_q  <= '0;
            state_q <= COMMIT;
          end else begin
            iter_q <= iter_q + 4'd1;
          end
        end
        default: begin
          range_err_q <= err_snap_q;
          if (err_snap_q) begin
            dig_q    <= {4{SEG_DASH}};
            dp_lit_q <= 1'b0;
          end else begin
            dig_q[3] <= (!mode_q && a_bcd_q[7:4] == 4'd0) ? SEG_BLANK : seg7(a_bcd_q[7:4]);
            dig_q[2] <= seg7(a_bcd_q[3:0]);
            dig_q[1] <= mode_q ? seg7(bcd_q[11:8]) : seg7(bcd_q[7:4]);
            dig_q[0] <= mode_q ? seg7(bcd_q[7:4])  : seg7(bcd_q[3:0]);
            dp_lit_q <= mode_q || !sec0_q;
          end
          state_q <= LOAD;
        end
      endcase
    end
  end

  always_ff @(posedge kh_clk or negedge reset) begin
    if (!reset) begin
      idx_q  <= '0;
      hold_q <= '0;
      an_q   <= '1;
      seg_q  <= SEG_BLANK;
      dp_q   <= 1'b1;
    end else begin
      if (hold_q >= 16'(DIGIT_HOLD - 1)) begin
        hold_q <= '0;
        idx_q  <= idx_q + 2'd1;
      end else begin
        hold_q <= hold_q + 16'd1;
      end
      an_q  <= ~(4'b0001 << idx_q);
      seg_q <= dig_q[idx_q];
      dp_q  <= !(dp_lit_q && idx_q == 2'd2);
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign range_err = range_err_q;

endmodule

// File: tb/tb_time_display_scan.sv
// Randomized self-checking bench for time_display_scan against an arithmetic display model.
module tb_time_display_scan;

  logic        kh_clk = 1'b0;
  logic        reset  = 1'b0;
  logic [26:0] disp_time = '0;
  logic        show_ms = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        range_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic an_chk = 1'b0;

  logic [6:0] SEG_TAB [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  time_display_scan #(.DIGIT_HOLD(1), .HR_ZERO_12(1'b1)) dut (
    .kh_clk(kh_clk), .reset(reset), .disp_time(disp_time), .show_ms(show_ms),
    .an(an), .seg(seg), .dp(dp), .range_err(range_err)
  );

  always #5 kh_clk = ~kh_clk;

  always @(posedge kh_clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge kh_clk) begin
    if (an_chk) check("an_onehot", 32'($countones(~an)), 32'd1);
  end

  function automatic logic [26:0] pack(input int hr, input int mn, input int sc, input int ms);
    return {5'(hr), 6'(mn), 6'(sc), 10'(ms)};
  endfunction

  task automatic model(input logic [26:0] t, input logic m,
                       output logic [6:0] es [4], output logic ed [4], output logic eerr);
    int hr, mn, sc, ms, a, b;
    int dg [4];
    hr = int'(t[26:22]); mn = int'(t[21:16]); sc = int'(t[15:10]); ms = int'(t[9:0]);
    eerr = (hr > 12) || (mn > 59) || (sc > 59) || (ms > 999);
    for (int i = 0; i < 4; i++) begin
      es[i] = 7'h3F;
      ed[i] = 1'b1;
    end
    if (!eerr) begin
      a = m ? sc : ((hr == 0) ? 12 : hr);
      b = m ? ms : mn;
      dg[3] = a / 10;
      dg[2] = a % 10;
      dg[1] = m ? b / 100 : b / 10;
      dg[0] = m ? (b / 10) % 10 : b % 10;
      for (int i = 0; i < 4; i++) es[i] = SEG_TAB[dg[i]];
      if (!m && dg[3] == 0) es[3] = 7'h7F;
      ed[2] = (m || (sc % 2) == 0) ? 1'b0 : 1'b1;
    end
  endtask

  // Checks range_err, then one full scan frame (skipping two cycles for the output register).
  task automatic check_frame(input string name, input logic [26:0] t, input logic m);
    logic [6:0] es [4];
    logic       ed [4];
    logic       eerr;
    int         idx;
    model(t, m, es, ed, eerr);
    check($sformatf("%s_range_err", name), 32'(range_err), 32'(eerr));
    repeat (2) @(negedge kh_clk);
    for (int c = 0; c < 8; c++) begin
      @(negedge kh_clk);
      idx = -1;
      for (int i = 0; i < 4; i++) if (an == ~(4'b0001 << i)) idx = i;
      if (idx >= 0) begin
        check($sformatf("%s_seg_d%0d", name, idx), 32'(seg), 32'(es[idx]));
        check($sformatf("%s_dp_d%0d", name, idx), 32'(dp), 32'(ed[idx]));
      end
    end
  endtask

  task automatic wait_phase(input int ph);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge kh_clk);
      if (cyc % 22 == ph) hit = 1'b1;
    end
    if (!hit) check("phase_timeout", 32'd0, 32'd1);
  endtask

  task automatic apply(input logic [26:0] t, input logic m);
    @(negedge kh_clk);
    disp_time = t;
    show_ms   = m;
  endtask

  task automatic check_reset_outputs(input string name);
    check($sformatf("%s_an", name), 32'(an), 32'hF);
    check($sformatf("%s_seg", name), 32'(seg), 32'h7F);
    check($sformatf("%s_dp", name), 32'(dp), 32'd1);
    check($sformatf("%s_range_err", name), 32'(range_err), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [26:0] t;
    logic        m;
    bit          seen;

    // Reset state and first pass after release
    repeat (3) @(negedge kh_clk);
    check_reset_outputs("rst");
    reset = 1'b1;
    @(negedge kh_clk);
    an_chk = 1'b1;
    repeat (20) @(negedge kh_clk);
    check("pre_commit_seg", 32'(seg), 32'h7F);
    check("pre_commit_dp", 32'(dp), 32'd1);
    check_frame("zero_hr12", pack(0, 0, 0, 0), 1'b0);

    t = pack(9, 5, 1, 0);
    apply(t, 1'b0);
    repeat (45) @(negedge kh_clk);
    check_frame("hr9", t, 1'b0);

    t = pack(3, 20, 59, 987);
    apply(t, 1'b1);
    repeat (45) @(negedge kh_clk);
    check_frame("ms_mode", t, 1'b1);

    // Out-of-range minute must be flagged within the latency bound
    t = pack(10, 60, 30, 500);
    apply(t, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 43 && !seen; k++) begin
      @(posedge kh_clk);
      #1 if (range_err) seen = 1'b1;
    end
    check("err_latency", 32'(seen), 32'd1);
    check_frame("err_dash", t, 1'b0);
    t = pack(10, 59, 30, 500);
    apply(t, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 45 && !seen; k++) begin
      @(posedge kh_clk);
      #1 if (!range_err) seen = 1'b1;
    end
    check("err_clear", 32'(seen), 32'd1);
    check_frame("err_restored", t, 1'b0);

    // Mode change mid-conversion only takes effect on the following pass
    t = pack(7, 42, 16, 354);
    apply(t, 1'b0);
    wait_phase(1);
    wait_phase(3);
    show_ms = 1'b1;
    wait_phase(0);
    check_frame("toggle_old", t, 1'b0);
    wait_phase(0);
    check_frame("toggle_new", t, 1'b1);

    for (int n = 0; n < 20; n++) begin
      t = pack($urandom_range(0, 14), $urandom_range(0, 62),
               $urandom_range(0, 62), $urandom_range(0, 1023));
      m = 1'($urandom_range(0, 1));
      apply(t, m);
      repeat (45) @(negedge kh_clk);
      check_frame($sformatf("rnd%0d", n), t, m);
    end

    // Reset mid-conversion, then timing of the first commit after release
    t = pack(5, 60, 5, 5);
    apply(t, 1'b0);
    repeat (45) @(negedge kh_clk);
    check("pre_abort_err", 32'(range_err), 32'd1);
    wait_phase(15);
    #2;
    an_chk = 1'b0;
    reset  = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (3) @(negedge kh_clk);
    reset = 1'b1;
    repeat (21) @(negedge kh_clk);
    check("commit_edge21", 32'(range_err), 32'd0);
    an_chk = 1'b1;
    @(negedge kh_clk);
    check("commit_edge22", 32'(range_err), 32'd1);
    check_frame("post_abort", t, 1'b0);

    an_chk = 1'b0;
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
